// File: rtl/oram_backend_model.sv
// ---------------------------------------------------------------------------
// oram_backend_model
//
// Synthesizable stand-in for the Path ORAM backend. Commands are accepted on
// a valid/ready handshake. Reads travel down a fixed-latency delay line into a
// small return FIFO and come back as ORAMB/FEDWidth beats, low bits first.
// Writes (Update/Append) consume Beats data beats. In memory mode the data is
// stored and read back. In pattern mode every returned ORAMU chunk i carries
// PAddr+i.
//
// Ports:
//   Clock, Reset           sole clock, asynchronous active-low reset
//   Command, PAddr         00 Update, 01 Append, 10 Read, 11 ReadRmv; address
//   CommandValid/Ready     command handshake
//   DataIn, Valid/Ready    write beat handshake
//   DataOut, Valid/Ready   read beat handshake
//   ReadCount, WriteCount  completed read / write commands (wrap mod 2^32)
//   Outstanding            reads accepted but not yet fully returned
// ---------------------------------------------------------------------------
module oram_backend_model #(
    parameter int ORAMU          = 32,
    parameter int ORAMB          = 512,
    parameter int FEDWidth       = 512,
    parameter int Latency        = 6,
    parameter int MaxOutstanding = 4,
    parameter int MemMode        = 0,
    parameter int MemDepthLog    = 6
) (
    input  logic                              Clock,
    input  logic                              Reset,
    input  logic [1:0]                        Command,
    input  logic [ORAMU-1:0]                  PAddr,
    input  logic                              CommandValid,
    output logic                              CommandReady,
    input  logic [FEDWidth-1:0]               DataIn,
    input  logic                              DataInValid,
    output logic                              DataInReady,
    output logic [FEDWidth-1:0]               DataOut,
    output logic                              DataOutValid,
    input  logic                              DataOutReady,
    output logic [31:0]                       ReadCount,
    output logic [31:0]                       WriteCount,
    output logic [$clog2(MaxOutstanding):0]   Outstanding
);

    localparam int Beats    = ORAMB / FEDWidth;
    localparam int BeatW    = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int Chunks   = ORAMB / ORAMU;
    localparam int MemDepth = 1 << MemDepthLog;
    localparam int PtrW     = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int OutW     = $clog2(MaxOutstanding) + 1;

    typedef enum logic {
        StateIdle,
        StateWData
    } stateT;

    typedef struct packed {
        logic             valid;
        logic             rmv;
        logic [ORAMU-1:0] addr;
    } lineT;

    stateT                  state;
    stateT                  stateNext;
    logic                   active;
    logic [MemDepthLog-1:0] writeIdx;
    logic [BeatW-1:0]       writeBeat;
    logic                   readAccept;
    logic                   writeAccept;
    logic                   dataInFire;
    logic                   writeLastBeat;

    logic [ORAMB-1:0]       mem [MemDepth];
    logic [MemDepth-1:0]    memValid;

    lineT                   acceptEntry;
    lineT                   fifoPush;

    logic [ORAMU-1:0]       fifoAddr [MaxOutstanding];
    logic                   fifoRmv  [MaxOutstanding];
    logic [PtrW-1:0]        wrPtr;
    logic [PtrW-1:0]        rdPtr;
    logic [OutW-1:0]        fifoCount;

    logic [ORAMU-1:0]       headAddr;
    logic                   headRmv;
    logic [MemDepthLog-1:0] headIdx;
    logic [ORAMB-1:0]       patternBlock;
    logic [ORAMB-1:0]       liveBlock;
    logic [ORAMB-1:0]       heldBlock;
    logic [ORAMB-1:0]       curBlock;
    logic                   blockHeld;
    logic [BeatW-1:0]       readBeat;
    logic                   dataOutFire;
    logic                   readLastFire;

    // Handshake decodes. Command[1] separates reads from writes and
    // Command[0] marks a read as a remove (ReadRmv).
    assign readAccept    = CommandValid && CommandReady && Command[1];
    assign writeAccept   = CommandValid && CommandReady && !Command[1];
    assign dataInFire    = DataInValid && DataInReady;
    assign writeLastBeat = dataInFire && (writeBeat == BeatW'(Beats - 1));

    // Write-side state machine, next state and handshake readies. Ready is
    // held low until the first clock after reset release so that every
    // output reads 0 while reset is asserted. Reads keep us in idle; writes
    // move to the data phase until the last beat has been taken.
    always_comb begin
        stateNext    = state;
        CommandReady = 1'b0;
        DataInReady  = 1'b0;
        case (state)
            StateIdle: begin
                CommandReady = active && (Outstanding < OutW'(MaxOutstanding));
                if (CommandValid && CommandReady && !Command[1]) begin
                    stateNext = StateWData;
                end
            end
            StateWData: begin
                DataInReady = 1'b1;
                if (DataInValid && (writeBeat == BeatW'(Beats - 1))) begin
                    stateNext = StateIdle;
                end
            end
            default: stateNext = StateIdle;
        endcase
    end

    // State register plus the write bookkeeping: the memory index latched
    // at command accept, the beat counter and the completed-write counter.
    // A reset in the middle of a write simply drops the partial block.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= StateIdle;
            active     <= 1'b0;
            writeIdx   <= '0;
            writeBeat  <= '0;
            WriteCount <= '0;
        end else begin
            active <= 1'b1;
            state  <= stateNext;
            if (writeAccept) begin
                writeIdx  <= PAddr[MemDepthLog-1:0];
                writeBeat <= '0;
            end else if (dataInFire) begin
                writeBeat <= writeLastBeat ? '0 : writeBeat + 1'b1;
            end
            if (writeLastBeat) begin
                WriteCount <= WriteCount + 1'b1;
            end
        end
    end

    // Block storage. Contents are deliberately not reset; only the valid
    // bits below decide whether a stored block is returned.
    always_ff @(posedge Clock) begin
        if (dataInFire) begin
            mem[writeIdx][int'(writeBeat)*FEDWidth +: FEDWidth] <= DataIn;
        end
    end

    // Per-block valid bits. A ReadRmv clears its block as its last beat is
    // taken. A write completing in the same cycle wins, because the write is
    // the newer event for that block.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            memValid <= '0;
        end else begin
            if (readLastFire && headRmv) begin
                memValid[headIdx] <= 1'b0;
            end
            if (writeLastBeat) begin
                memValid[writeIdx] <= 1'b1;
            end
        end
    end

    assign acceptEntry = {readAccept, Command[0], PAddr};

    // Fixed-latency delay line. The return FIFO adds one more register, so
    // Latency-1 stages here put the first beat on DataOut exactly Latency
    // cycles after the accept cycle. With Latency==1 the accept writes the
    // FIFO directly.
    generate
        if (Latency > 1) begin : gDelay
            lineT stages [Latency-1];

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    for (int i = 0; i < Latency - 1; i++) begin
                        stages[i] <= '0;
                    end
                end else begin
                    stages[0] <= acceptEntry;
                    for (int i = 1; i < Latency - 1; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign fifoPush = stages[Latency-2];
        end else begin : gNoDelay
            assign fifoPush = acceptEntry;
        end
    endgenerate

    // Return FIFO. It never overflows because Outstanding counts every read
    // still in the delay line or in here, and accepts stop at the limit.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                fifoAddr[i] <= '0;
                fifoRmv[i]  <= 1'b0;
            end
        end else begin
            if (fifoPush.valid) begin
                fifoAddr[wrPtr] <= fifoPush.addr;
                fifoRmv[wrPtr]  <= fifoPush.rmv;
                wrPtr <= (wrPtr == PtrW'(MaxOutstanding - 1)) ? '0 : wrPtr + 1'b1;
            end
            if (readLastFire) begin
                rdPtr <= (rdPtr == PtrW'(MaxOutstanding - 1)) ? '0 : rdPtr + 1'b1;
            end
            case ({fifoPush.valid, readLastFire})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    assign headAddr = fifoAddr[rdPtr];
    assign headRmv  = fifoRmv[rdPtr];
    assign headIdx  = headAddr[MemDepthLog-1:0];

    // Pattern block for the FIFO head: chunk i is PAddr+i, wrapping at the
    // chunk width. Stored data replaces it only in memory mode for a valid
    // block.
    always_comb begin
        patternBlock = '0;
        for (int i = 0; i < Chunks; i++) begin
            patternBlock[i*ORAMU +: ORAMU] = headAddr + ORAMU'(i);
        end
    end

    assign liveBlock = ((MemMode != 0) && memValid[headIdx]) ? mem[headIdx] : patternBlock;

    // The block is taken live while beat 0 is first presented and frozen
    // from the next cycle on, so later writes or backpressure cannot change
    // a return that has already started.
    assign curBlock     = blockHeld ? heldBlock : liveBlock;
    assign DataOutValid = (fifoCount != '0);
    assign DataOut      = DataOutValid ? curBlock[int'(readBeat)*FEDWidth +: FEDWidth] : '0;
    assign dataOutFire  = DataOutValid && DataOutReady;
    assign readLastFire = dataOutFire && (readBeat == BeatW'(Beats - 1));

    // Return sequencing: beat counter, block capture and completed-read
    // counter. A stalled beat simply keeps readBeat where it is.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            readBeat  <= '0;
            blockHeld <= 1'b0;
            heldBlock <= '0;
            ReadCount <= '0;
        end else begin
            if (dataOutFire) begin
                readBeat <= readLastFire ? '0 : readBeat + 1'b1;
            end
            if (readLastFire) begin
                blockHeld <= 1'b0;
            end else if (DataOutValid && !blockHeld) begin
                blockHeld <= 1'b1;
                heldBlock <= liveBlock;
            end
            if (readLastFire) begin
                ReadCount <= ReadCount + 1'b1;
            end
        end
    end

    // Reads in flight. An accept and a completion in the same cycle cancel.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Outstanding <= '0;
        end else begin
            case ({readAccept, readLastFire})
                2'b10:   Outstanding <= Outstanding + 1'b1;
                2'b01:   Outstanding <= Outstanding - 1'b1;
                default: Outstanding <= Outstanding;
            endcase
        end
    end

endmodule

// File: doc/oram_backend_model.md
Name: oram_backend_model

Overview:
- Synthesizable, parametrised stand-in for the Path ORAM backend, used by hardware test harnesses in place of the real backend.
- Accepts backend commands and returns read blocks as FEDWidth beats after a programmable fixed latency.
- Supports multiple outstanding reads and two modes:
  - Pattern: each returned ORAMU chunk i = PAddr+i.
  - Memory: write data is stored and read back.
- Uses no simulation delays and exposes access counters.

Parameters:
- ORAMU, 32, address/chunk width.
- ORAMB, 512, block width; must be a multiple of FEDWidth.
- FEDWidth, 512, data-beat width; Beats = ORAMB/FEDWidth.
- Latency, 6, cycles from read accept to first return beat; must be >= 1.
- MaxOutstanding, 4, max reads accepted but not fully returned.
- MemMode, 0, 0 = pattern mode, 1 = memory mode.
- MemDepthLog, 6, memory mode: 2^MemDepthLog blocks, indexed by PAddr[MemDepthLog-1:0].

Ports:
- Clock  in  1  sole clock.
- Reset  in  1  asynchronous, active-low reset.
- Command  in  2  00 Update, 01 Append, 10 Read, 11 ReadRmv.
- PAddr  in  ORAMU  block address.
- CommandValid  in  1  command handshake valid.
- CommandReady  out  1  command handshake ready.
- DataIn  in  FEDWidth  write beat.
- DataInValid  in  1  write beat valid.
- DataInReady  out  1  write beat ready.
- DataOut  out  FEDWidth  read beat.
- DataOutValid  out  1  read beat valid.
- DataOutReady  in  1  read beat ready.
- ReadCount  out  32  completed read commands.
- WriteCount  out  32  completed write commands.
- Outstanding  out  log2(MaxOutstanding)+1  reads in flight.

Behaviour:
- Reset (Reset=0, async): all outputs 0; state IDLE; counters 0; delay line and return FIFO cleared; memory valid bits cleared (memory contents left undefined). Reset mid-block discards partial writes and reads.
- Handshakes fire on Valid&Ready. Valid never depends on Ready. Data held while Valid&~Ready.
- State machine (write side):
  - IDLE: CommandReady = (Outstanding < MaxOutstanding).
    - Read/ReadRmv accepted: push {PAddr, rmv} into the Latency-deep delay line; stay IDLE.
    - Update/Append accepted: latch PAddr, go to WDATA.
  - WDATA: CommandReady=0, DataInReady=1; beat counter 0..Beats-1.
    - Memory mode: beat k is written to mem[idx] bits [(k+1)*FEDWidth-1 : k*FEDWidth]; valid[idx] is set on the last beat.
    - Pattern mode: data is discarded.
    - Last beat: WriteCount++, return to IDLE.
- Delay line: an entry reaches the return FIFO (depth MaxOutstanding) exactly Latency cycles after acceptance. With an empty FIFO and DataOutReady=1, the first beat is valid at accept cycle + Latency.
- Return: the FIFO head is emitted as Beats consecutive beats, beat 0 = low bits.
  - Pattern mode, or memory mode with valid[idx]=0: block = concat over i of (PAddr+i), each ORAMU wide, wrapping mod 2^ORAMU.
  - Memory mode with valid[idx]=1: data is mem[idx] as it reads when beat 0 is first presented.
  - ReadRmv: clears valid[idx] when the last beat handshakes.
  - Last beat handshake: pop FIFO, ReadCount++, Outstanding--.
- Outstanding: increments on read accept, decrements on last-beat handshake. A simultaneous increment and decrement leaves it unchanged. CommandReady is low while it equals MaxOutstanding, so the FIFO never overflows.
- Backpressure: DataOutReady=0 holds the current beat. Delay-line entries keep advancing into the FIFO.
- Counters wrap modulo 2^32.
- Reads accepted during the same cycle a write completes are legal. Reads are returned strictly in accept order.

Test Plan:
- Pattern, Beats=1, Latency=6: Read PAddr=0x10 at cycle t -> DataOutValid at t+6; chunk0=0x10, chunk15=0x1F; ReadCount=1.
- Pattern, FEDWidth=128 (Beats=4): Read PAddr=0xFFFFFFFE -> 4 beats; beat0 chunks 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Outstanding: MaxOutstanding=4, DataOutReady=0, issue 5 Reads -> 4 accepted; CommandReady=0 until first last-beat handshake; returns in issue order.
- Memory mode: Update PAddr=3 with pattern A, then Read 3 -> returns A. ReadRmv 3 -> returns A; a following Read 3 returns the pattern for 3.
- Backpressure: toggle DataOutReady every cycle during a 4-beat return -> each beat held stable; no loss or duplication; single ReadCount++.
- Reset asserted mid-WDATA and with 2 reads in flight -> all outputs 0 immediately; after release, Outstanding=0 and no stale DataOutValid.
